// File: rtl/pipeline_pkg.sv
// Shared pipeline types: default register-file widths and the write-back entry layout
// used by the decode stage and the write-back buffer.
package pipeline_pkg;

  localparam int WB_WIDTH        = 8;
  localparam int WB_ADDRESSWIDTH = 3;

  typedef struct packed {
    logic [WB_ADDRESSWIDTH-1:0] address;
    logic [WB_WIDTH-1:0]        data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order {address, data} FIFO for the write-back buffer. Push is refused when full,
// pop is ignored when empty; the whole entry array is exposed for the forwarding search.
module wb_fifo #(
  parameter int WIDTH        = 8,
  parameter int ADDRESSWIDTH = 3,
  parameter int DEPTH        = 4,
  localparam int EW = ADDRESSWIDTH + WIDTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [EW-1:0]             push_entry,
  input  logic                      pop,
  output logic [CW-1:0]             count,
  output logic                      full,
  output logic                      empty,
  output logic [PW-1:0]             head_ptr,
  output logic [EW-1:0]             head_entry,
  output logic [DEPTH-1:0][EW-1:0]  entries
);

  logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     do_push, do_pop;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign count      = count_q;
  assign head_ptr   = head_q;
  assign head_entry = mem_q[head_q];
  assign entries    = mem_q;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[tail_q] = push_entry;
      tail_d        = tail_q + 1'b1;
    end
    if (do_pop) head_d = head_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Register-file write-side buffer: queues results and drains one per cycle unless held.
// Forwarding of buffered results to the decode read ports is built only with WB_FORWARD_EN.
module writeback_buffer
  import pipeline_pkg::*;
#(
  parameter int WIDTH        = WB_WIDTH,
  parameter int ADDRESSWIDTH = WB_ADDRESSWIDTH,
  parameter int DEPTH        = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    resultValid,
  output logic                    resultReady,
  input  logic [ADDRESSWIDTH-1:0] resultAddress,
  input  logic [WIDTH-1:0]        resultData,
  input  logic                    hold,
  output logic                    writeEnable,
  output logic [ADDRESSWIDTH-1:0] writeAddress,
  output logic [WIDTH-1:0]        dataToSave,
  input  logic [ADDRESSWIDTH-1:0] reg1Address,
  input  logic [ADDRESSWIDTH-1:0] reg2Address,
  output logic                    fwd1Valid,
  output logic                    fwd2Valid,
  output logic [WIDTH-1:0]        fwd1Data,
  output logic [WIDTH-1:0]        fwd2Data
);

  localparam int EW = ADDRESSWIDTH + WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDRESSWIDTH-1:0] address;
    logic [WIDTH-1:0]        data;
  } entry_t;

  logic [DEPTH-1:0][EW-1:0] entries;
  logic [EW-1:0]            head_raw;
  entry_t                   head, incoming;
  logic [CW-1:0]            count;
  logic [PW-1:0]            head_ptr;
  logic                     full, empty;

  assign incoming = '{address: resultAddress, data: resultData};
  assign head     = head_raw;

  wb_fifo #(.WIDTH(WIDTH), .ADDRESSWIDTH(ADDRESSWIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (resultValid),
    .push_entry (incoming),
    .pop        (writeEnable),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .head_ptr   (head_ptr),
    .head_entry (head_raw),
    .entries    (entries)
  );

  assign resultReady  = !full;
  assign writeEnable  = !empty && !hold;
  assign writeAddress = empty ? '0 : head.address;
  assign dataToSave   = empty ? '0 : head.data;

`ifdef WB_FORWARD_EN
  entry_t fwd_e;

  // Walk oldest to youngest so the last match wins (youngest write-after-write value).
  always_comb begin
    fwd1Valid = 1'b0;
    fwd2Valid = 1'b0;
    fwd1Data  = '0;
    fwd2Data  = '0;
    fwd_e     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        fwd_e = entries[head_ptr + PW'(i)];
        if (fwd_e.address == reg1Address) begin
          fwd1Valid = 1'b1;
          fwd1Data  = fwd_e.data;
        end
        if (fwd_e.address == reg2Address) begin
          fwd2Valid = 1'b1;
          fwd2Data  = fwd_e.data;
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{entries, count, head_ptr, reg1Address, reg2Address};
  assign fwd1Valid  = 1'b0;
  assign fwd2Valid  = 1'b0;
  assign fwd1Data   = '0;
  assign fwd2Data   = '0;
`endif

endmodule
